// File: rtl/imem_loader.sv
// imem_loader: parses a framed boot byte stream into little-endian instruction
// words, writes them plus a halt terminator, and releases cpu_hold on a good checksum.
module imem_loader #(
    parameter int              DEPTH     = 256,
    parameter int              ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [7:0]      MAGIC     = 8'hA5,
    parameter logic [31:0]     HALT_WORD = 32'h00000063
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_data,
    output logic                       wr_en,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [31:0]                wr_data,
    output logic [$clog2(DEPTH):0]     words_loaded,
    output logic                       done,
    output logic                       error,
    output logic                       cpu_hold
);
    localparam int WL_W = $clog2(DEPTH) + 1;
    typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, CHECK, TERM, DONE, ERROR} state_t;
    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        chk_q, chk_d;
    logic [1:0]        idx_q, idx_d;
    logic [23:0]       asm_q, asm_d;
    logic [WL_W-1:0]   wl_q, wl_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic [15:0]       n;
    assign n = {rx_data, cnt_q[7:0]};
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        chk_d      = chk_q;
        idx_d      = idx_q;
        asm_d      = asm_q;
        wl_d       = wl_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = done_q;
        error_d    = error_q;
        cpu_hold_d = cpu_hold_q;
        case (state_q)
            IDLE, DONE, ERROR: if (rx_valid && rx_data == MAGIC) begin
                state_d    = CNT_LO;
                cnt_d      = '0;
                chk_d      = '0;
                idx_d      = '0;
                wl_d       = '0;
                done_d     = 1'b0;
                error_d    = 1'b0;
                cpu_hold_d = 1'b1;
            end
            CNT_LO: if (rx_valid) begin
                cnt_d[7:0] = rx_data;
                chk_d      = chk_q ^ rx_data;
                state_d    = CNT_HI;
            end
            CNT_HI: if (rx_valid) begin
                cnt_d   = n;
                chk_d   = chk_q ^ rx_data;
                state_d = (int'(n) > DEPTH) ? ERROR : (n == 16'd0) ? CHECK : DATA;
                error_d = int'(n) > DEPTH;
            end
            DATA: if (rx_valid) begin
                chk_d = chk_q ^ rx_data;
                asm_d = {rx_data, asm_q[23:8]};
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = BASE_ADDR + (ADDR_W'(wl_q) << 2);
                    wr_data_d = {rx_data, asm_q};
                    wl_d      = wl_q + 1'b1;
                    if (int'(wl_q) + 1 == int'(cnt_q)) state_d = CHECK;
                end
            end
            CHECK: if (rx_valid) begin
                if (rx_data != chk_q) begin
                    state_d = ERROR;
                    error_d = 1'b1;
                end else if (int'(cnt_q) < DEPTH) begin
                    state_d   = TERM;
                    wr_en_d   = 1'b1;
                    wr_addr_d = BASE_ADDR + (ADDR_W'(cnt_q) << 2);
                    wr_data_d = HALT_WORD;
                end else begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
                end
            end
            TERM: begin
                state_d    = DONE;
                done_d     = 1'b1;
                cpu_hold_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            chk_q      <= '0;
            idx_q      <= '0;
            asm_q      <= '0;
            wl_q       <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            cpu_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            chk_q      <= chk_d;
            idx_q      <= idx_d;
            asm_q      <= asm_d;
            wl_q       <= wl_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            error_q    <= error_d;
            cpu_hold_q <= cpu_hold_d;
        end
    end
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign words_loaded = wl_q;
    assign done         = done_q;
    assign error        = error_q;
    assign cpu_hold     = cpu_hold_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames against imem_loader with hand-computed write lists.
module tb_imem_loader;
    typedef logic [7:0] bq_t[$];
    logic        clk = 1'b0;
    logic        rst, rx_valid;
    logic [7:0]  rx_data;
    logic        wr_en, done, error, cpu_hold;
    logic [31:0] wr_addr, wr_data;
    logic [8:0]  words_loaded;
    int n_cmp = 0, n_bad = 0, cyc = 0;
    logic [31:0] qa[$], qd[$];
    int qc[$];
    logic [31:0] e1_a[3] = '{32'h0, 32'h4, 32'h8};
    logic [31:0] e1_d[3] = '{32'h00500093, 32'h00100113, 32'h00000063};
    bq_t f1 = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC3};

    imem_loader dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .words_loaded(words_loaded), .done(done), .error(error), .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (wr_en === 1'b1) begin
        qa.push_back(wr_addr);
        qd.push_back(wr_data);
        qc.push_back(cyc);
    end

    // Returns at the negedge right after the edge that accepted the last byte.
    task automatic send_frame(input bq_t b, input bit gap);
        foreach (b[i]) begin
            @(negedge clk); rx_valid = 1'b1; rx_data = b[i];
            if (gap) begin @(negedge clk); rx_valid = 1'b0; end
        end
        if (!gap) begin @(negedge clk); rx_valid = 1'b0; end
    endtask

    task automatic clear_log;
        @(negedge clk);
        qa.delete(); qd.delete(); qc.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++; if ({wr_en, wr_addr, wr_data} !== 65'd0) begin n_bad++; $display("FAIL reset_wr: got %0b %0h %0h want 0 0 0", wr_en, wr_addr, wr_data); end
        n_cmp++; if (words_loaded !== 9'd0) begin n_bad++; $display("FAIL reset_words: got %0d want 0", words_loaded); end
        n_cmp++; if ({done, error, cpu_hold} !== 3'b001) begin n_bad++; $display("FAIL reset_flags: got %03b want 001", {done, error, cpu_hold}); end
        rst = 1'b0;
        clear_log();
    endtask

    task automatic test_frame1;
        clear_log();
        send_frame(f1, 1'b0);
        n_cmp++; if ({wr_en, wr_data, done} !== {1'b1, 32'h63, 1'b0}) begin n_bad++; $display("FAIL f1_term: got en=%0b data=%0h done=%0b want 1 63 0", wr_en, wr_data, done); end
        @(negedge clk);
        n_cmp++; if ({done, cpu_hold, wr_en, error} !== 4'b1000) begin n_bad++; $display("FAIL f1_done: got %04b want 1000", {done, cpu_hold, wr_en, error}); end
        n_cmp++; if (words_loaded !== 9'd2) begin n_bad++; $display("FAIL f1_words: got %0d want 2", words_loaded); end
        n_cmp++; if (qa.size() !== 3) begin n_bad++; $display("FAIL f1_count: got %0d want 3", qa.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++; if (qa[i] !== e1_a[i] || qd[i] !== e1_d[i]) begin n_bad++; $display("FAIL f1_write%0d: got (%0h,%0h) want (%0h,%0h)", i, qa[i], qd[i], e1_a[i], e1_d[i]); end
            end
            n_cmp++; if (qc[1] - qc[0] !== 4) begin n_bad++; $display("FAIL f1_spacing: got %0d want 4", qc[1] - qc[0]); end
        end
    endtask

    task automatic test_zero;
        clear_log();
        send_frame('{8'hA5, 8'h00, 8'h00, 8'h00}, 1'b0);
        n_cmp++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 32'h0, 32'h63}) begin n_bad++; $display("FAIL zero_term: got %0b %0h %0h want 1 0 63", wr_en, wr_addr, wr_data); end
        @(negedge clk);
        n_cmp++; if ({done, cpu_hold} !== 2'b10 || words_loaded !== 9'd0) begin n_bad++; $display("FAIL zero_done: got done=%0b hold=%0b words=%0d want 1 0 0", done, cpu_hold, words_loaded); end
        n_cmp++; if (qa.size() !== 1) begin n_bad++; $display("FAIL zero_count: got %0d want 1", qa.size()); end
    endtask

    task automatic test_oversize;
        clear_log();
        send_frame('{8'hA5, 8'h01, 8'h01}, 1'b0);
        n_cmp++; if ({error, done, cpu_hold, wr_en} !== 4'b1010) begin n_bad++; $display("FAIL over_err: got %04b want 1010", {error, done, cpu_hold, wr_en}); end
        repeat (3) @(negedge clk);
        n_cmp++; if (qa.size() !== 0) begin n_bad++; $display("FAIL over_writes: got %0d want 0", qa.size()); end
        clear_log();
        send_frame(f1, 1'b0);
        @(negedge clk);
        n_cmp++; if ({error, done, cpu_hold} !== 3'b010) begin n_bad++; $display("FAIL over_reload: got %03b want 010", {error, done, cpu_hold}); end
        n_cmp++; if (qa.size() !== 3 || qd[0] !== e1_d[0] || qd[2] !== e1_d[2]) begin n_bad++; $display("FAIL over_reload_writes: got n=%0d", qa.size()); end
    endtask

    task automatic test_bad_chk;
        bq_t f = f1;
        f[11] = 8'hC2;
        clear_log();
        send_frame(f, 1'b0);
        n_cmp++; if ({error, done, cpu_hold, wr_en} !== 4'b1010) begin n_bad++; $display("FAIL chk_err: got %04b want 1010", {error, done, cpu_hold, wr_en}); end
        @(negedge clk);
        n_cmp++; if (qa.size() !== 2) begin n_bad++; $display("FAIL chk_writes: got %0d want 2", qa.size()); end
        n_cmp++; if ({error, done, cpu_hold} !== 3'b101) begin n_bad++; $display("FAIL chk_hold: got %03b want 101", {error, done, cpu_hold}); end
    endtask

    task automatic test_full;
        bq_t f = '{8'hA5, 8'h00, 8'h01};
        logic [7:0] c = 8'h01;
        int bad = 0;
        for (int i = 0; i < 256; i++) begin
            f.push_back(8'(i)); f.push_back(8'h00); f.push_back(8'h00); f.push_back(8'h00);
            c = c ^ 8'(i);
        end
        f.push_back(c);
        clear_log();
        send_frame(f, 1'b0);
        n_cmp++; if ({done, cpu_hold, wr_en, error} !== 4'b1000) begin n_bad++; $display("FAIL full_done: got %04b want 1000", {done, cpu_hold, wr_en, error}); end
        repeat (2) @(negedge clk);
        n_cmp++; if (qa.size() !== 256) begin n_bad++; $display("FAIL full_count: got %0d want 256", qa.size()); end
        else begin
            for (int i = 0; i < 256; i++) if (qa[i] !== 32'(4 * i) || qd[i] !== 32'(i)) bad++;
            n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL full_writes: got %0d wrong want 0", bad); end
            n_cmp++; if (qa[255] !== 32'h3FC) begin n_bad++; $display("FAIL full_last: got %0h want 3fc", qa[255]); end
        end
        n_cmp++; if (words_loaded !== 9'd256) begin n_bad++; $display("FAIL full_words: got %0d want 256", words_loaded); end
    endtask

    task automatic test_gapped;
        clear_log();
        send_frame(f1, 1'b1);
        n_cmp++; if ({wr_en, wr_data} !== {1'b1, 32'h63}) begin n_bad++; $display("FAIL gap_term: got %0b %0h want 1 63", wr_en, wr_data); end
        @(negedge clk);
        n_cmp++; if ({done, cpu_hold} !== 2'b10) begin n_bad++; $display("FAIL gap_done: got %02b want 10", {done, cpu_hold}); end
        n_cmp++; if (qa.size() !== 3) begin n_bad++; $display("FAIL gap_count: got %0d want 3", qa.size()); end
        else for (int i = 0; i < 3; i++) begin
            n_cmp++; if (qa[i] !== e1_a[i] || qd[i] !== e1_d[i]) begin n_bad++; $display("FAIL gap_write%0d: got (%0h,%0h) want (%0h,%0h)", i, qa[i], qd[i], e1_a[i], e1_d[i]); end
        end
    endtask

    task automatic test_reset_mid;
        clear_log();
        send_frame('{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50}, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({wr_en, wr_addr, wr_data, words_loaded} !== 74'd0) begin n_bad++; $display("FAIL mid_rst_wr: got %0b %0h %0h %0d want zeros", wr_en, wr_addr, wr_data, words_loaded); end
        n_cmp++; if ({done, error, cpu_hold} !== 3'b001) begin n_bad++; $display("FAIL mid_rst_flags: got %03b want 001", {done, error, cpu_hold}); end
        rst = 1'b0;
        clear_log();
        send_frame(f1, 1'b0);
        @(negedge clk);
        n_cmp++; if ({done, cpu_hold} !== 2'b10 || words_loaded !== 9'd2) begin n_bad++; $display("FAIL mid_reload: got done=%0b hold=%0b words=%0d want 1 0 2", done, cpu_hold, words_loaded); end
        n_cmp++; if (qa.size() !== 3 || qd[1] !== e1_d[1] || qa[2] !== e1_a[2]) begin n_bad++; $display("FAIL mid_reload_writes: got n=%0d", qa.size()); end
    endtask

    initial begin
        test_reset();
        test_frame1();
        test_zero();
        test_oversize();
        test_bad_chk();
        test_full();
        test_gapped();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a framed byte stream from a host-side byte receiver and assembles little-endian 32-bit instruction words.
- Drives a synchronous word-write port into instruction storage, then appends a halt terminator word.
- Holds the core in reset (cpu_hold) until a load completes with a valid checksum.
- Sits between the boot byte source and the instruction memory write port.

Parameters:
- DEPTH, 256, instruction memory depth in 32-bit words.
- ADDR_W, 32, width of wr_addr (byte address).
- BASE_ADDR, 32'h0, byte address of word 0.
- MAGIC, 8'hA5, frame start byte.
- HALT_WORD, 32'h00000063, terminator instruction (beq x0,x0,0).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- rx_valid  input  1  rx_data is valid this cycle; one byte is consumed per cycle, with no backpressure.
- rx_data  input  8  stream byte.
- wr_en  output  1  one-cycle word write strobe.
- wr_addr  output  ADDR_W  byte address, word aligned: BASE_ADDR + 4*index.
- wr_data  output  32  word to write.
- words_loaded  output  $clog2(DEPTH)+1  data words written in the current or last frame.
- done  output  1  load complete and checksum good.
- error  output  1  frame rejected.
- cpu_hold  output  1  keep the core in reset.

Behaviour:
- Frame format: MAGIC, CNT_LO, CNT_HI (16-bit word count N, little-endian), 4*N data bytes (each word least-significant byte first), then CHK.
  - CHK is the XOR of CNT_LO, CNT_HI and all data bytes. MAGIC is excluded.
- All outputs are registered. Reset values: wr_en=0, wr_addr=0, wr_data=0, words_loaded=0, done=0, error=0, cpu_hold=1, state=IDLE.
- Reset asserted mid-frame aborts the frame and returns to IDLE with the reset values above. Words already written are not undone.
- Bytes are consumed only on edges where rx_valid=1. Cycles with rx_valid=0 are ignored in every state.
- States and transitions:
  - IDLE: a byte equal to MAGIC clears the checksum and counters, then goes to CNT_LO. Any other byte is discarded.
  - CNT_LO: latch the low count byte, go to CNT_HI.
  - CNT_HI: latch the high count byte.
    - If N > DEPTH, go to ERROR immediately; no data is written.
    - If N == 0, go to CHECK.
    - Otherwise go to DATA.
  - DATA: shift the byte into a 32-bit assembler and keep a byte index 0..3.
    - On the edge accepting byte 3, register wr_en=1, wr_addr=BASE_ADDR+4*words_loaded, wr_data=assembled word, and increment words_loaded.
    - wr_en is 1 in the following cycle only.
    - After word N-1, go to CHECK.
  - CHECK: compare the received byte with the running XOR.
    - Mismatch: go to ERROR.
    - Match and N < DEPTH: go to TERM. On that same edge, register wr_en=1, wr_addr=BASE_ADDR+4*N, wr_data=HALT_WORD.
    - Match and N == DEPTH: go to DONE directly, with no terminator.
  - TERM: lasts exactly one cycle, then DONE. Any rx byte arriving during TERM is dropped.
  - DONE: done=1, cpu_hold=0, error=0.
  - ERROR: error=1, done=0, cpu_hold=1.
  - From DONE or ERROR, a MAGIC byte starts a new frame: done=0, error=0, cpu_hold=1, words_loaded=0, go to CNT_LO. Other bytes are ignored.
- Byte-to-write latency: wr_en is high in the cycle immediately after the edge that accepted the 4th byte of the word.
- Back-to-back words with rx_valid held high give one write every 4 cycles.
- A MAGIC value appearing inside count, data or CHK positions is treated as data, not as a restart.
- The terminator write does not increment words_loaded.
- words_loaded saturates at DEPTH by construction, because N > DEPTH is rejected.

Test Plan:
1. Reset, then stream A5 02 00 93 00 50 00 13 01 10 00 C3 with rx_valid held high.
   - Required: writes (0,00500093), (4,00100113), (8,00000063).
   - done=1 and cpu_hold=0 one cycle after the terminator write; words_loaded=2.
2. Stream A5 00 00 00 (N=0).
   - Required: a single write (0,00000063), then done=1.
3. Stream A5 01 01 (N=257).
   - Required: error=1 on the edge after CNT_HI, no wr_en pulses, cpu_hold=1.
   - Then stream frame 1: it must load correctly and clear error.
4. Stream frame 1 with CHK=C2.
   - Required: the two data writes occur but no terminator, error=1, done=0, cpu_hold=1.
5. Stream N=256 (A5 00 01) with incrementing words and a correct CHK.
   - Required: 256 writes, last at addr 0x3FC, no terminator, done=1.
6. Cover two corner cases:
   - Gapped rx_valid (one idle cycle between each byte) gives the same writes as scenario 1.
   - Asserting rst after the 6th byte returns outputs to reset values; a fresh frame then loads normally.
